// File: rtl/room_hud_blitter.sv
// Room/HUD blitter: streams room tiles or HUD hearts into the frame buffer.
// Optional HUD_BORDER_EN paints the bottom HUD row with BORDER_COLOR.
module room_hud_blitter #(
    parameter int         SCREEN_W     = 320,
    parameter int         SCREEN_H     = 240,
    parameter int         HUD_H        = 16,
    parameter int         HEART_W      = 16,
    parameter int         ADDR_W       = 17,
    parameter logic [7:0] HEART_COLOR  = 8'hE0,
    parameter logic [7:0] HUD_BG       = 8'h00
`ifdef HUD_BORDER_EN
    ,
    parameter logic [7:0] BORDER_COLOR = 8'hFF
`endif
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DrawRoomEN,
    input  logic              DrawHudEN,
    input  logic [2:0]        PlayerHealth,
    input  logic [1:0]        TileSel,
    output logic [9:0]        TileAddr,
    input  logic [7:0]        TileData,
    output logic [ADDR_W-1:0] FB_Addr,
    output logic [7:0]        FB_Data,
    output logic              FB_WE,
    output logic              DrawRoomDone,
    output logic              DrawHudDone
);

    localparam int XW    = $clog2(SCREEN_W);
    localparam int YW    = $clog2(SCREEN_H);
    localparam int HW    = (HEART_W > 1) ? $clog2(HEART_W) : 1;
    localparam int NSLOT = (SCREEN_W + HEART_W - 1) / HEART_W;
    localparam int SW    = $clog2(NSLOT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ROOM,
        HUD,
        ROOM_DONE,
        HUD_DONE
    } state_t;

    state_t state, state_nx;

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] row_base;
    logic [HW-1:0]     hx;
    logic [SW-1:0]     slot;
    logic [2:0]        health;
    logic              drain;

    logic              p_valid;
    logic              p_room;
    logic [ADDR_W-1:0] p_addr;
    logic [7:0]        p_color;

    logic              issue;
    logic              last_pix;
    logic [7:0]        hud_color;
    logic [3:0]        ry;

    // Next-state: requests, completion after drain, abort on EN drop
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (DrawRoomEN)
                    state_nx = ROOM;
                else if (DrawHudEN)
                    state_nx = HUD;
            end
            ROOM: begin
                if (!DrawRoomEN)
                    state_nx = IDLE;
                else if (drain)
                    state_nx = ROOM_DONE;
            end
            HUD: begin
                if (!DrawHudEN)
                    state_nx = IDLE;
                else if (drain)
                    state_nx = HUD_DONE;
            end
            ROOM_DONE: begin
                if (!DrawRoomEN)
                    state_nx = IDLE;
            end
            HUD_DONE: begin
                if (!DrawHudEN)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage 0: pixel issue, end-of-scan detect and HUD colour
    always_comb begin
        issue     = 1'b0;
        last_pix  = 1'b0;
        hud_color = HUD_BG;
        ry        = 4'(y - YW'(HUD_H));
        if (state == ROOM) begin
            issue    = DrawRoomEN && !drain;
            last_pix = (x == XW'(SCREEN_W - 1)) &&
                       (y == YW'(SCREEN_H - 1));
        end else if (state == HUD) begin
            issue    = DrawHudEN && !drain;
            last_pix = (x == XW'(SCREEN_W - 1)) &&
                       (y == YW'(HUD_H - 1));
        end
        if (int'(slot) < int'(health))
            hud_color = HEART_COLOR;
`ifdef HUD_BORDER_EN
        if (y == YW'(HUD_H - 1))
            hud_color = BORDER_COLOR;
`endif
    end

    assign TileAddr     = (state == ROOM) ? {TileSel, ry, x[3:0]} : 10'd0;
    assign FB_WE        = p_valid;
    assign FB_Addr      = p_addr;
    assign FB_Data      = p_room ? TileData : p_color;
    assign DrawRoomDone = (state == ROOM_DONE);
    assign DrawHudDone  = (state == HUD_DONE);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Raster counters, row base and stage-1 pixel register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            hx       <= '0;
            slot     <= '0;
            health   <= '0;
            drain    <= 1'b0;
            p_valid  <= 1'b0;
            p_room   <= 1'b0;
            p_addr   <= '0;
            p_color  <= '0;
        end else begin
            p_valid <= issue;
            if (issue) begin
                p_addr  <= row_base + ADDR_W'(x);
                p_room  <= (state == ROOM);
                p_color <= (state == HUD) ? hud_color : 8'h00;
            end
            if (state == IDLE && state_nx == ROOM) begin
                x        <= '0;
                y        <= YW'(HUD_H);
                row_base <= ADDR_W'(HUD_H * SCREEN_W);
                hx       <= '0;
                slot     <= '0;
                drain    <= 1'b0;
            end else if (state == IDLE && state_nx == HUD) begin
                x        <= '0;
                y        <= '0;
                row_base <= '0;
                hx       <= '0;
                slot     <= '0;
                drain    <= 1'b0;
                health   <= PlayerHealth;
            end else if (issue) begin
                if (last_pix) begin
                    drain <= 1'b1;
                end else if (x == XW'(SCREEN_W - 1)) begin
                    x        <= '0;
                    y        <= y + 1'b1;
                    row_base <= row_base + ADDR_W'(SCREEN_W);
                    hx       <= '0;
                    slot     <= '0;
                end else begin
                    x <= x + 1'b1;
                    if (hx == HW'(HEART_W - 1)) begin
                        hx   <= '0;
                        slot <= slot + 1'b1;
                    end else begin
                        hx <= hx + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_room_hud_blitter.sv
// Scoreboard bench for room_hud_blitter on a small 32x12 screen.
// Covers room fill, HUD hearts, health latch, priority/abort and reset.
module tb_room_hud_blitter;

    localparam int W  = 32;
    localparam int H  = 12;
    localparam int HH = 4;
    localparam int HW = 8;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          room_en;
    logic          hud_en;
    logic [2:0]    health;
    logic [1:0]    tile_sel;
    logic [9:0]    tile_addr;
    logic [7:0]    tile_data = 8'h00;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          fb_we;
    logic          room_done;
    logic          hud_done;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } px_t;

    px_t sb[$];
    int  n_chk    = 0;
    int  n_err    = 0;
    int  n_wr     = 0;
    int  first_wr = -1;
    int  last_wr  = -1;
    int  cyc      = 0;
    int  t0;
    int  at;

    always #5 clk = ~clk;

    room_hud_blitter #(
        .SCREEN_W(W),
        .SCREEN_H(H),
        .HUD_H   (HH),
        .HEART_W (HW),
        .ADDR_W  (AW)
    ) dut (
        .CLK         (clk),
        .RESET       (reset),
        .DrawRoomEN  (room_en),
        .DrawHudEN   (hud_en),
        .PlayerHealth(health),
        .TileSel     (tile_sel),
        .TileAddr    (tile_addr),
        .TileData    (tile_data),
        .FB_Addr     (fb_addr),
        .FB_Data     (fb_data),
        .FB_WE       (fb_we),
        .DrawRoomDone(room_done),
        .DrawHudDone (hud_done)
    );

    always @(posedge clk) tile_data <= tile_addr[7:0];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        px_t e;
        if (fb_we === 1'b1) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (sb.size() == 0) begin
                check("unexpected_we", 32'(fb_we), 32'd0);
            end else begin
                e = sb.pop_front();
                check("fb_addr", 32'(fb_addr), 32'(e.a));
                check("fb_data", 32'(fb_data), 32'(e.d));
            end
        end
    end

    task automatic clear_stats();
        n_wr     = 0;
        first_wr = -1;
        last_wr  = -1;
    endtask

    task automatic push_room();
        for (int y = HH; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                px_t p;
                p.a = AW'(y * W + x);
                p.d = {4'(y - HH), 4'(x)};
                sb.push_back(p);
            end
        end
    endtask

    task automatic push_hud(input int h);
        for (int y = 0; y < HH; y++) begin
            for (int x = 0; x < W; x++) begin
                px_t p;
                p.a = AW'(y * W + x);
                p.d = ((x / HW) < h) ? 8'hE0 : 8'h00;
`ifdef HUD_BORDER_EN
                if (y == HH - 1) p.d = 8'hFF;
`endif
                sb.push_back(p);
            end
        end
    endtask

    task automatic wait_done(input bit room, input int budget,
                             output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if ((room ? room_done : hud_done) === 1'b1) begin
                when = cyc;
                break;
            end
        end
        if (room) check("room_done_seen", 32'(room_done), 32'd1);
        else check("hud_done_seen", 32'(hud_done), 32'd1);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (n_wr >= n) break;
        end
        check("writes_reached", 32'(n_wr >= n), 32'd1);
    endtask

    task automatic run_hud(input int h, input bit change);
        @(negedge clk); #1;
        push_hud(h);
        clear_stats();
        t0     = cyc;
        health = 3'(h);
        hud_en = 1'b1;
        if (change) begin
            wait_writes(10, 50);
            health = 3'd4;
        end
        wait_done(1'b0, 300, at);
        check("hud_first_we", 32'(first_wr - t0), 32'd2);
        check("hud_done_cyc", 32'(at - t0), 32'd130);
        check("hud_writes", 32'(n_wr), 32'd128);
        check("hud_sb_empty", 32'(sb.size()), 32'd0);
        hud_en = 1'b0;
        @(negedge clk); #1;
        check("hud_done_drop", 32'(hud_done), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        room_en  = 1'b0;
        hud_en   = 1'b0;
        health   = 3'd0;
        tile_sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_data", 32'(fb_data), 32'd0);
        check("rst_tile_addr", 32'(tile_addr), 32'd0);
        check("rst_room_done", 32'(room_done), 32'd0);
        check("rst_hud_done", 32'(hud_done), 32'd0);
        reset = 1'b0;

        // room fill
        @(negedge clk); #1;
        push_room();
        clear_stats();
        t0       = cyc;
        tile_sel = 2'b01;
        room_en  = 1'b1;
        @(posedge clk); #1;
        check("first_tile_addr", 32'(tile_addr), 32'h100);
        wait_done(1'b1, 400, at);
        check("room_first_we", 32'(first_wr - t0), 32'd2);
        check("room_last_we", 32'(last_wr - t0), 32'd257);
        check("room_done_cyc", 32'(at - t0), 32'd258);
        check("room_writes", 32'(n_wr), 32'd256);
        check("room_sb_empty", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("room_done_hold", 32'(room_done), 32'd1);
        room_en = 1'b0;
        @(negedge clk); #1;
        check("room_done_drop", 32'(room_done), 32'd0);

        // HUD, health latch, empty health
        run_hud(2, 1'b0);
        run_hud(2, 1'b1);
        run_hud(0, 1'b0);

        // priority then abort, HUD follows
        @(negedge clk); #1;
        push_room();
        clear_stats();
        health  = 3'd3;
        room_en = 1'b1;
        hud_en  = 1'b1;
        wait_writes(50, 100);
        room_en = 1'b0;
        @(negedge clk); #1;
        check("abort_we", 32'(fb_we), 32'd0);
        check("abort_room_done", 32'(room_done), 32'd0);
        check("abort_hud_done", 32'(hud_done), 32'd0);
        check("abort_writes", 32'(n_wr), 32'd50);
        sb.delete();
        push_hud(3);
        clear_stats();
        t0 = cyc;
        wait_done(1'b0, 300, at);
        check("post_abort_first_we", 32'(first_wr - t0), 32'd2);
        check("post_abort_writes", 32'(n_wr), 32'd128);
        check("post_abort_sb", 32'(sb.size()), 32'd0);
        hud_en = 1'b0;
        @(negedge clk); #1;
        check("post_abort_drop", 32'(hud_done), 32'd0);

        // reset mid-room, then restart
        push_room();
        clear_stats();
        room_en = 1'b1;
        wait_writes(20, 100);
        reset   = 1'b1;
        room_en = 1'b0;
        @(negedge clk); #1;
        check("mid_rst_we", 32'(fb_we), 32'd0);
        check("mid_rst_room_done", 32'(room_done), 32'd0);
        check("mid_rst_hud_done", 32'(hud_done), 32'd0);
        reset = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        #1;
        check("mid_rst_no_writes", 32'(n_wr), 32'd20);
        push_room();
        clear_stats();
        t0      = cyc;
        room_en = 1'b1;
        wait_done(1'b1, 400, at);
        check("restart_first_we", 32'(first_wr - t0), 32'd2);
        check("restart_writes", 32'(n_wr), 32'd256);
        check("restart_sb", 32'(sb.size()), 32'd0);
        room_en = 1'b0;
        @(negedge clk); #1;
        check("restart_drop", 32'(room_done), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
